// File: rtl/mbox_arb_pkg.sv
// mbox_arb_pkg
// Shared types and constants for the MBOX request arbiter slice.
//   state_t : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   owner_t : owner encoding driven on the arbiter's owner output
//   ADR_W   : physical address width (bits 13..35)
//   WORD_W  : data word width (bits 0..35)
package mbox_arb_pkg;

  localparam int ADR_W  = 23;
  localparam int WORD_W = 36;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_SWEEP = 2'd1,
    OWN_EBOX  = 2'd2,
    OWN_CHAN  = 2'd3
  } owner_t;

endpackage

// File: rtl/mbox_arb_pick.sv
// mbox_arb_pick
// Combinational winner selection among the three MBOX requesters.
// Sweep always wins. Between EBOX and channel the choice is fixed priority
// (EBOX first) unless MBOX_ARB_RR_EN is defined, in which case the parent's
// round-robin pointer decides a tie.
// Ports:
//   sweepReq, eboxReq, chanReq : request inputs
//   rrChan                     : (MBOX_ARB_RR_EN only) 1 = channel favoured
//   win                        : selected owner, OWN_NONE if no request
module mbox_arb_pick
  import mbox_arb_pkg::*;
(
  input  logic   sweepReq,
  input  logic   eboxReq,
  input  logic   chanReq,
`ifdef MBOX_ARB_RR_EN
  input  logic   rrChan,
`endif
  output owner_t win
);

  always_comb begin
    win = OWN_NONE;
    if (sweepReq) begin
      win = OWN_SWEEP;
    end else if (eboxReq && chanReq) begin
`ifdef MBOX_ARB_RR_EN
      win = rrChan ? OWN_CHAN : OWN_EBOX;
`else
      win = OWN_EBOX;
`endif
    end else if (eboxReq) begin
      win = OWN_EBOX;
    end else if (chanReq) begin
      win = OWN_CHAN;
    end
  end

endmodule

// File: rtl/mbox_req_arb.sv
// mbox_req_arb
// Sequencer/arbiter for the single MBOX memory port. Grants one of sweep,
// EBOX or channel, drives the MBOX request handshake, waits for completion,
// then returns read data with a one-cycle done pulse to the owner. A request
// that sees no completion within TIMEOUT cycles is aborted with nxmErr.
// Optional feature macro: MBOX_ARB_RR_EN (EBOX/channel round-robin).
// Ports:
//   clk, reset                       : clock, async active-high reset
//   sweepReq/sweepAdr                : cache-sweep write-back request
//   ebox{Req,Read,Write,PSE,VMA,WData}: EBOX request
//   chan{Req,Read,Write,Adr,WData}   : channel request
//   mbox{Req,Read,Write,PSE,Adr,WData}: request to MBOX (registered)
//   mboxAck, mboxDone, mboxRData     : MBOX handshake/response
//   sweepDone, eboxDone, chanDone    : one-cycle completion pulses
//   rData                            : read data, valid with done
//   nxmErr                           : timeout pulse, coincident with done
//   owner                            : 0 none, 1 sweep, 2 ebox, 3 chan
module mbox_req_arb
  import mbox_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sweepReq,
  input  logic [ADR_W-1:0]  sweepAdr,
  input  logic              eboxReq,
  input  logic              eboxRead,
  input  logic              eboxWrite,
  input  logic              eboxPSE,
  input  logic [ADR_W-1:0]  eboxVMA,
  input  logic [WORD_W-1:0] eboxWData,
  input  logic              chanReq,
  input  logic              chanRead,
  input  logic              chanWrite,
  input  logic [ADR_W-1:0]  chanAdr,
  input  logic [WORD_W-1:0] chanWData,
  output logic              mboxReq,
  output logic              mboxRead,
  output logic              mboxWrite,
  output logic              mboxPSE,
  output logic [ADR_W-1:0]  mboxAdr,
  output logic [WORD_W-1:0] mboxWData,
  input  logic              mboxAck,
  input  logic              mboxDone,
  input  logic [WORD_W-1:0] mboxRData,
  output logic              sweepDone,
  output logic              eboxDone,
  output logic              chanDone,
  output logic [WORD_W-1:0] rData,
  output logic              nxmErr,
  output logic [1:0]        owner
);

  localparam logic [7:0] LAST = TIMEOUT - 8'd1;

  state_t     state;
  owner_t     ownerQ;
  owner_t     win;
  logic [7:0] cnt;
  logic       complete;
  logic       expire;

`ifdef MBOX_ARB_RR_EN
  logic rrChan;
`endif

  mbox_arb_pick u_pick (
    .sweepReq (sweepReq),
    .eboxReq  (eboxReq),
    .chanReq  (chanReq),
`ifdef MBOX_ARB_RR_EN
    .rrChan   (rrChan),
`endif
    .win      (win)
  );

  // Completion beats timeout when both land in the same cycle; the counter
  // reaching TIMEOUT on this cycle's increment is what triggers the abort.
  always_comb begin
    complete = ((state == ST_ISSUE) && mboxAck && mboxDone) ||
               ((state == ST_WAIT) && mboxDone);
    expire   = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
               !complete && (cnt == LAST);
  end

  assign owner = ownerQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ownerQ    <= OWN_NONE;
      cnt       <= '0;
      mboxReq   <= 1'b0;
      mboxRead  <= 1'b0;
      mboxWrite <= 1'b0;
      mboxPSE   <= 1'b0;
      mboxAdr   <= '0;
      mboxWData <= '0;
      sweepDone <= 1'b0;
      eboxDone  <= 1'b0;
      chanDone  <= 1'b0;
      rData     <= '0;
      nxmErr    <= 1'b0;
`ifdef MBOX_ARB_RR_EN
      rrChan    <= 1'b0;
`endif
    end else begin
      sweepDone <= 1'b0;
      eboxDone  <= 1'b0;
      chanDone  <= 1'b0;
      nxmErr    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win != OWN_NONE) begin
            ownerQ  <= win;
            state   <= ST_ISSUE;
            mboxReq <= 1'b1;
            cnt     <= '0;
            case (win)
              OWN_SWEEP: begin
                mboxAdr   <= sweepAdr;
                mboxRead  <= 1'b0;
                mboxWrite <= 1'b1;
                mboxPSE   <= 1'b0;
                mboxWData <= '0;
              end
              OWN_EBOX: begin
                mboxAdr   <= eboxVMA;
                mboxRead  <= eboxRead;
                mboxWrite <= eboxWrite;
                mboxPSE   <= eboxPSE;
                mboxWData <= eboxWData;
`ifdef MBOX_ARB_RR_EN
                rrChan    <= 1'b1;
`endif
              end
              default: begin
                mboxAdr   <= chanAdr;
                mboxRead  <= chanRead;
                mboxWrite <= chanWrite;
                mboxPSE   <= 1'b0;
                mboxWData <= chanWData;
`ifdef MBOX_ARB_RR_EN
                rrChan    <= 1'b0;
`endif
              end
            endcase
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (complete || expire) begin
            state     <= ST_DONE;
            mboxReq   <= 1'b0;
            rData     <= expire ? '0 : mboxRData;
            nxmErr    <= expire;
            sweepDone <= (ownerQ == OWN_SWEEP);
            eboxDone  <= (ownerQ == OWN_EBOX);
            chanDone  <= (ownerQ == OWN_CHAN);
          end else begin
            cnt <= cnt + 8'd1;
            if ((state == ST_ISSUE) && mboxAck) begin
              state   <= ST_WAIT;
              mboxReq <= 1'b0;
            end
          end
        end
        default: begin
          ownerQ <= OWN_NONE;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbox_req_arb.sv
// tb_mbox_req_arb
// Directed bench for mbox_req_arb (TIMEOUT=8). Stimulus pushes expected
// completions into a scoreboard queue; a monitor pops and compares whenever
// a done or nxmErr pulse appears.
module tb_mbox_req_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sweepReq = 1'b0;
  logic [22:0] sweepAdr = '0;
  logic        eboxReq = 1'b0, eboxRead = 1'b0, eboxWrite = 1'b0, eboxPSE = 1'b0;
  logic [22:0] eboxVMA = '0;
  logic [35:0] eboxWData = '0;
  logic        chanReq = 1'b0, chanRead = 1'b0, chanWrite = 1'b0;
  logic [22:0] chanAdr = '0;
  logic [35:0] chanWData = '0;
  logic        mboxReq, mboxRead, mboxWrite, mboxPSE;
  logic [22:0] mboxAdr;
  logic [35:0] mboxWData;
  logic        mboxAck = 1'b0, mboxDone = 1'b0;
  logic [35:0] mboxRData = '0;
  logic        sweepDone, eboxDone, chanDone;
  logic [35:0] rData;
  logic        nxmErr;
  logic [1:0]  owner;

  typedef struct packed {
    logic [1:0]  own;
    logic [35:0] data;
    logic        nxm;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntotal = 0;

  mbox_req_arb #(.TIMEOUT(8'd8)) dut (
    .clk(clk), .reset(reset),
    .sweepReq(sweepReq), .sweepAdr(sweepAdr),
    .eboxReq(eboxReq), .eboxRead(eboxRead), .eboxWrite(eboxWrite),
    .eboxPSE(eboxPSE), .eboxVMA(eboxVMA), .eboxWData(eboxWData),
    .chanReq(chanReq), .chanRead(chanRead), .chanWrite(chanWrite),
    .chanAdr(chanAdr), .chanWData(chanWData),
    .mboxReq(mboxReq), .mboxRead(mboxRead), .mboxWrite(mboxWrite),
    .mboxPSE(mboxPSE), .mboxAdr(mboxAdr), .mboxWData(mboxWData),
    .mboxAck(mboxAck), .mboxDone(mboxDone), .mboxRData(mboxRData),
    .sweepDone(sweepDone), .eboxDone(eboxDone), .chanDone(chanDone),
    .rData(rData), .nxmErr(nxmErr), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [2:0] done_vec(input logic [1:0] own);
    case (own)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Monitor: any done or nxmErr pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (sweepDone || eboxDone || chanDone || nxmErr)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {61'd0, sweepDone, eboxDone, chanDone}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_vec", {61'd0, sweepDone, eboxDone, chanDone}, {61'd0, done_vec(e.own)});
        chk("done_owner", {62'd0, owner}, {62'd0, e.own});
        chk("rData", {28'd0, rData}, {28'd0, e.data});
        chk("nxmErr", {63'd0, nxmErr}, {63'd0, e.nxm});
      end
    end
  end

  task automatic wait_req();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mboxReq) begin ok = 1; break; end
    end
    if (!ok) chk("mboxReq_timeout", {63'd0, mboxReq}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sweepReq = 0; eboxReq = 0; chanReq = 0;
    eboxRead = 0; eboxWrite = 0; eboxPSE = 0; chanRead = 0; chanWrite = 0;
    mboxAck = 0; mboxDone = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_own [4];
    int cyc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mboxReq", {63'd0, mboxReq}, 64'd0);
    chk("rst_owner", {62'd0, owner}, 64'd0);
    chk("rst_dones", {61'd0, sweepDone, eboxDone, chanDone}, 64'd0);
    chk("rst_rData", {28'd0, rData}, 64'd0);
    reset = 1'b0;

    // EBOX read, ack+done in first ISSUE cycle
    @(negedge clk);
    eboxReq = 1; eboxRead = 1; eboxVMA = 23'h00100;
    sb.push_back('{own: 2'd2, data: 36'o123456701234, nxm: 1'b0});
    chk("t1_req_idle", {63'd0, mboxReq}, 64'd0);
    @(negedge clk);
    chk("t1_mboxReq", {63'd0, mboxReq}, 64'd1);
    chk("t1_adr", {41'd0, mboxAdr}, 64'h100);
    chk("t1_qual", {61'd0, mboxRead, mboxWrite, mboxPSE}, 64'b100);
    chk("t1_owner", {62'd0, owner}, 64'd2);
    mboxAck = 1; mboxDone = 1; mboxRData = 36'o123456701234;
    @(negedge clk);
    chk("t1_req_drop", {63'd0, mboxReq}, 64'd0);
    mboxAck = 0; mboxDone = 0; eboxReq = 0; eboxRead = 0;
    @(negedge clk);
    chk("t1_owner_clr", {62'd0, owner}, 64'd0);

    // Sweep and EBOX together: sweep first, then EBOX right after
    sweepReq = 1; sweepAdr = 23'h12345;
    eboxReq = 1; eboxWrite = 1; eboxVMA = 23'h00200; eboxWData = 36'o777;
    sb.push_back('{own: 2'd1, data: 36'o11, nxm: 1'b0});
    sb.push_back('{own: 2'd2, data: 36'o22, nxm: 1'b0});
    @(negedge clk);
    chk("t2_owner_sweep", {62'd0, owner}, 64'd1);
    chk("t2_sweep_qual", {61'd0, mboxRead, mboxWrite, mboxPSE}, 64'b010);
    chk("t2_sweep_adr", {41'd0, mboxAdr}, 64'h12345);
    mboxAck = 1;
    @(negedge clk);
    chk("t2_wait_noreq", {63'd0, mboxReq}, 64'd0);
    mboxAck = 0; mboxDone = 1; mboxRData = 36'o11;
    @(negedge clk);
    mboxDone = 0; sweepReq = 0;
    @(negedge clk);
    chk("t2_idle_gap", {62'd0, owner}, 64'd0);
    @(negedge clk);
    chk("t2_owner_ebox", {62'd0, owner}, 64'd2);
    chk("t2_ebox_adr", {41'd0, mboxAdr}, 64'h200);
    chk("t2_ebox_wdata", {28'd0, mboxWData}, 64'o777);
    mboxAck = 1; mboxDone = 1; mboxRData = 36'o22;
    @(negedge clk);
    mboxAck = 0; mboxDone = 0; eboxReq = 0; eboxWrite = 0;
    @(negedge clk);

    // EBOX and channel held continuously
    do_reset();
`ifdef MBOX_ARB_RR_EN
    exp_own = '{2'd2, 2'd3, 2'd2, 2'd3};
`else
    exp_own = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    eboxReq = 1; eboxRead = 1; eboxVMA = 23'h00100;
    chanReq = 1; chanRead = 1; chanAdr = 23'h00300;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      chk($sformatf("t3_owner%0d", i), {62'd0, owner}, {62'd0, exp_own[i]});
      chk($sformatf("t3_adr%0d", i), {41'd0, mboxAdr},
          (exp_own[i] == 2'd2) ? 64'h100 : 64'h300);
      mboxAck = 1; mboxDone = 1; mboxRData = 36'(100 + i);
      sb.push_back('{own: exp_own[i], data: 36'(100 + i), nxm: 1'b0});
      @(negedge clk);
      mboxAck = 0; mboxDone = 0;
      if (i == 3) begin eboxReq = 0; chanReq = 0; end
    end
    @(negedge clk);

    // Timeout: ack but no done
    eboxReq = 1; eboxRead = 1; eboxVMA = 23'h00500;
    wait_req();
    mboxAck = 1;
    sb.push_back('{own: 2'd2, data: 36'd0, nxm: 1'b1});
    mboxRData = 36'o7070;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mboxAck = 0;
      cyc++;
      if (eboxDone) break;
    end
    chk("t4_timeout_cycles", 64'(cyc), 64'd8);
    eboxReq = 0; eboxRead = 0;
    @(negedge clk);
    mboxDone = 1;
    @(negedge clk);
    mboxDone = 0;
    chk("t4_late_done", {61'd0, sweepDone, eboxDone, chanDone}, 64'd0);
    chk("t4_late_owner", {62'd0, owner}, 64'd0);
    @(negedge clk);
    chk("t4_late_req", {63'd0, mboxReq}, 64'd0);

    // Reset while in WAIT
    eboxReq = 1; eboxRead = 1; eboxVMA = 23'h00400;
    wait_req();
    mboxAck = 1;
    @(negedge clk);
    mboxAck = 0;
    chk("t5_owner_wait", {62'd0, owner}, 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_owner", {62'd0, owner}, 64'd0);
    chk("t5_rst_req", {63'd0, mboxReq}, 64'd0);
    chk("t5_rst_read", {63'd0, mboxRead}, 64'd0);
    chk("t5_rst_dones", {61'd0, sweepDone, eboxDone, chanDone}, 64'd0);
    eboxReq = 0; eboxRead = 0; mboxDone = 1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mboxDone = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("t5_no_done%0d", i), {61'd0, sweepDone, eboxDone, chanDone}, 64'd0);
    end
    chanReq = 1; chanRead = 1; chanAdr = 23'h00300;
    sb.push_back('{own: 2'd3, data: 36'o55, nxm: 1'b0});
    wait_req();
    chk("t5_fresh_owner", {62'd0, owner}, 64'd3);
    chk("t5_fresh_adr", {41'd0, mboxAdr}, 64'h300);
    mboxAck = 1; mboxDone = 1; mboxRData = 36'o55;
    @(negedge clk);
    mboxAck = 0; mboxDone = 0; chanReq = 0; chanRead = 0;
    repeat (2) @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
